// File: rtl/skid_pipe_reg.sv
// Two-entry valid/ready skid buffer. Every handshake output comes from a flop,
// so out_ready has no combinational path to in_ready.
module skid_pipe_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             wr, rd;
  logic             load_main_in, load_main_skid, load_skid;
  logic [CW-1:0]    count_nxt;

  assign wr       = in_valid & in_ready;
  assign rd       = out_valid & out_ready;
  assign out_data = main_q;

  // Next state and register load selects
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (wr) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (wr && rd) begin
          load_main_in = 1'b1;
        end else if (wr) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (rd) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (rd) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    count_nxt = CW'(0);
    case (state_nxt)
      ONE:     count_nxt = CW'(1);
      FULL:    count_nxt = CW'(2);
      default: count_nxt = CW'(0);
    endcase
  end

  // State plus handshake outputs registered from the next state
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= CW'(0);
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
      count     <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_q <= WIDTH'(0);
      skid_q <= WIDTH'(0);
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Bench for skid_pipe_reg: directed vector table, hand sequences, and random
// traffic scored against an occupancy-queue model.
module tb_skid_pipe_reg;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, out_ready;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] in_data, out_data;
  logic [1:0]       count;

  int n_pass  = 0;
  int n_total = 0;

  skid_pipe_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, fl, iv;
    logic [7:0] d;
    logic       ordy;
    logic       ev, er;
    logic [1:0] ec;
    logic       dchk;
    logic [7:0] ed;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(int rst, int fl, int iv, int d, int ordy,
                              int ev, int er, int ec, int dchk, int ed);
    vec_t v;
    v.rst = 1'(rst); v.fl = 1'(fl); v.iv = 1'(iv); v.d = 8'(d); v.ordy = 1'(ordy);
    v.ev = 1'(ev); v.er = 1'(er); v.ec = 2'(ec); v.dchk = 1'(dchk); v.ed = 8'(ed);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of at most two words
  logic [7:0] q[$];
  logic       zeroed = 1'b1;
  int         reads  = 0;

  task automatic model_step();
    logic w, r;
    if (reset || flush) begin
      q.delete();
      zeroed = 1'b1;
    end else begin
      w = in_valid && (q.size() < 2);
      r = out_ready && (q.size() > 0);
      if (r) begin
        void'(q.pop_front());
        reads++;
      end
      if (w) begin
        q.push_back(in_data);
        zeroed = 1'b0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    check({tag, " in_ready"},  32'(in_ready),  32'(q.size() < 2));
    check({tag, " count"},     32'(count),     32'(q.size()));
    if (q.size() > 0)  check({tag, " out_data"}, 32'(out_data), 32'(q[0]));
    else if (zeroed)   check({tag, " out_data"}, 32'(out_data), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    model_step();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;

    //          rst fl iv data  ordy  ev er ec dchk data
    vecs[0]  = mk(1, 0, 1, 'hFF, 0,   0, 1, 0, 1, 'h00);
    vecs[1]  = mk(1, 0, 1, 'hFF, 0,   0, 1, 0, 1, 'h00);
    vecs[2]  = mk(1, 0, 1, 'hFF, 0,   0, 1, 0, 1, 'h00);
    vecs[3]  = mk(0, 0, 1, 'h12, 0,   1, 1, 1, 1, 'h12);
    vecs[4]  = mk(0, 0, 1, 'h34, 0,   1, 0, 2, 1, 'h12);
    vecs[5]  = mk(0, 0, 1, 'h56, 0,   1, 0, 2, 1, 'h12);
    vecs[6]  = mk(0, 0, 0, 'h00, 1,   1, 1, 1, 1, 'h34);
    vecs[7]  = mk(0, 0, 0, 'h00, 1,   0, 1, 0, 0, 'h00);
    vecs[8]  = mk(0, 0, 1, 'hAA, 0,   1, 1, 1, 1, 'hAA);
    vecs[9]  = mk(0, 0, 1, 'hBB, 0,   1, 0, 2, 1, 'hAA);
    vecs[10] = mk(0, 1, 0, 'h00, 1,   0, 1, 0, 1, 'h00);
    vecs[11] = mk(0, 0, 1, 'hCC, 0,   1, 1, 1, 1, 'hCC);
    vecs[12] = mk(0, 0, 0, 'h00, 1,   0, 1, 0, 0, 'h00);
    vecs[13] = mk(0, 0, 1, 'hDD, 0,   1, 1, 1, 1, 'hDD);
    vecs[14] = mk(0, 1, 1, 'hEE, 1,   0, 1, 0, 1, 'h00);
    vecs[15] = mk(0, 0, 0, 'h00, 0,   0, 1, 0, 1, 'h00);

    for (int i = 0; i < 16; i++) begin
      reset = vecs[i].rst; flush = vecs[i].fl; in_valid = vecs[i].iv;
      in_data = vecs[i].d; out_ready = vecs[i].ordy;
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].er));
      check($sformatf("vec%0d count", i),     32'(count),     32'(vecs[i].ec));
      if (vecs[i].dchk)
        check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].ed));
    end
    flush = 1'b0; reset = 1'b0;

    // Streaming: one word per clock, count steady at 1
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = 8'(i);
      tick();
      check($sformatf("stream%0d out_data", i), 32'(out_data), 32'(i));
      check($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'h1);
      check($sformatf("stream%0d count", i),    32'(count),    32'h1);
    end
    in_valid = 1'b0;
    tick();
    check("stream drain count", 32'(count), 32'h0);
    check("stream drain out_valid", 32'(out_valid), 32'h0);

    // FULL holds indefinitely, then reset mid-transfer discards everything
    in_valid = 1'b1; out_ready = 1'b0; in_data = 8'h77;
    tick();
    in_data = 8'h88;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold%0d count", i),    32'(count),    32'h2);
      check($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'h0);
      check($sformatf("hold%0d out_data", i), 32'(out_data), 32'h77);
    end
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h99;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("midreset count", 32'(count), 32'h0);
    check("midreset out_valid", 32'(out_valid), 32'h0);
    check("midreset out_data", 32'(out_data), 32'h0);
    tick();
    check("midreset no resurrect", 32'(out_valid), 32'h0);

    // Random traffic against the model
    do_reset();
    check_model("post reset");
    reads = 0;
    for (int cyc = 0; cyc < 20000 && reads < 1000; cyc++) begin
      in_valid  = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      in_data   = 8'($urandom);
      flush     = (($urandom % 64) == 0);
      model_step();
      tick();
      check_model($sformatf("rand%0d", cyc));
    end
    flush = 1'b0;
    check("random words read", 32'(reads >= 1000), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
